data_memory_ctl: RTL and testbench
==================================

# data_memory_ctl

Parametrised byte-addressed data memory with a request/ready handshake, programmable wait states and byte/halfword/word access with sign or zero extension on loads. It sits on the CPU's MEM stage in place of the fixed word-only memory. The CPU issues one request, stalls on Ready, and gets an Error flag for misaligned, out-of-range or illegal-size accesses instead of silent corruption.

## Interface
- ADDR_WIDTH, 8: byte-address bits used; depth is 2^ADDR_WIDTH bytes.
- WAIT_STATES, 1: extra cycles before each access completes (legal range 0..15).
- BIG_ENDIAN, 1: 1 means the lowest address holds the most significant byte; 0 means little-endian.
- CLK  in  1  clock; all state changes on posedge.
- RST  in  1  synchronous reset, active-low.
- Req  in  1  request strobe; sampled only in IDLE.
- Write  in  1  1 = store, 0 = load; captured with Req.
- Size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- Unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend; ignored for word loads and stores.
- Address  in  32  byte address; captured with Req.
- WriteData  in  32  store data, right-aligned (byte in [7:0], half in [15:0]); captured with Req.
- Busy  out  1  high whenever state is not IDLE.
- Ready  out  1  one-cycle completion pulse.
- Error  out  1  valid with Ready; 1 = request rejected.
- ReadData  out  32  load result; updated only on a successful load completion, held otherwise.

## Operation
- Storage is 2^ADDR_WIDTH bytes. Memory contents are not reset; simulation initial contents are X.
- FSM states:
  - IDLE: Req=1 captures Write, Size, Unsigned, Address and WriteData.
    - Capture is rejected if Size=11, if Address[31:ADDR_WIDTH] is nonzero, if the access is misaligned (half with A[0]=1, word with A[1:0] not 00), or if the last byte falls beyond depth. A rejected request goes to DONE with Error=1 and no memory access.
    - Otherwise the FSM loads the wait counter with WAIT_STATES and goes to ACCESS.
  - ACCESS: if counter is nonzero, decrement. If counter is 0, perform the access on this edge, then go to DONE with Error=0.
  - DONE: Ready=1 for exactly one cycle, then unconditional return to IDLE.
- Req is ignored in ACCESS and DONE; no queuing. The requester must hold or reissue Req in IDLE.
- Big-endian byte lanes (BIG_ENDIAN=1):
  - Word load: ReadData = {M[A], M[A+1], M[A+2], M[A+3]}.
  - Half load: {ext16, M[A], M[A+1]}.
  - Byte load: {ext24, M[A]}.
  - ext is the replicated MSB of the loaded data when Unsigned=0, otherwise zeros.
- Stores write WriteData right-aligned using the same lane order, touching only Size bytes.
- BIG_ENDIAN=0 reverses the lane order within the accessed unit.
- Stores leave ReadData unchanged.
- A rejected request leaves memory and ReadData unchanged.

## Timing
- Reset (RST=0 at a posedge):
  - State goes to IDLE, Busy=0, Ready=0, Error=0, ReadData=0, counter=0.
  - Any in-flight store is aborted and not committed.
  - RST has priority over Req.
- Request accepted at posedge k; Busy=1 from k.
- Good request:
  - Memory is written, or ReadData loaded, at posedge k+1+WAIT_STATES.
  - Ready/Error are visible in the cycle after that edge and drop at posedge k+2+WAIT_STATES.
- Rejected request: Ready=1 and Error=1 in the cycle following posedge k, dropping at k+1.
- Minimum request spacing:
  - WAIT_STATES+3 cycles between good acceptances.
  - 2 cycles between rejected ones.
- A load completing immediately after a store to the same address returns the new data. There is no bypass; the store commits before any later access starts.
- Error is 0 whenever Ready is 0.

## Test plan
- W=0, BIG_ENDIAN=1: store word 0x11223344 at 0x04, then load word at 0x04. Required: Ready at k+1 after each acceptance; ReadData=0x11223344; byte load at 0x04 returns 0x00000011.
- Byte store 0x80 at 0x09, then byte load at 0x09 with Unsigned=0 -> 0xFFFFFF80; with Unsigned=1 -> 0x00000080.
- Half store 0xBEEF at 0x0A, then half load with Unsigned=0 -> 0xFFFFBEEF. A half store at 0x0B returns Error=1 one cycle after acceptance, and a word load at 0x08 shows bytes 0x0A/0x0B unchanged.
- WAIT_STATES=3: accept a load at posedge k. Required: Ready exactly in the cycle after posedge k+4. Req pulses during ACCESS produce no extra Ready pulses.
- Out-of-range and illegal requests, ADDR_WIDTH=8: address 0x100 word load -> Error=1, ReadData held. Size=11 -> Error=1.
- Reset mid-store (WAIT_STATES=3, RST=0 at posedge k+2): Busy=0 and Ready=0 next cycle; a later load of that address returns the prior contents.

Source files
------------

// File: rtl/data_memory_ctl.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_ctl
// Purpose  : Byte-addressed data memory for the CPU MEM stage. One request is
//            accepted at a time through a Req/Ready handshake. A programmable
//            number of wait states precedes each access. Byte, half and word
//            accesses are supported, and loads are sign- or zero-extended.
//            Misaligned, out-of-range and illegal-size requests complete with
//            Error=1 and leave memory and ReadData untouched.
// Ports    : CLK       - clock, all state changes on the rising edge
//            RST       - synchronous reset, active-low
//            Req       - request strobe, sampled only while idle
//            Write     - 1 = store, 0 = load
//            Size      - 00 byte, 01 half, 10 word, 11 illegal
//            Unsigned  - loads: 1 = zero-extend, 0 = sign-extend
//            Address   - byte address
//            WriteData - store data, right-aligned
//            Busy      - high whenever the controller is not idle
//            Ready     - one-cycle completion pulse
//            Error     - qualifies Ready; 1 = request rejected
//            ReadData  - load result, held between successful loads
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_ctl #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 1,
    parameter bit BIG_ENDIAN  = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Req,
    input  logic        Write,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic        Busy,
    output logic        Ready,
    output logic        Error,
    output logic [31:0] ReadData
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                  state_q,    state_d;
    logic [3:0]              cnt_q,      cnt_d;
    logic                    write_q,    write_d;
    logic [2:0]              nbytes_q,   nbytes_d;
    logic                    unsigned_q, unsigned_d;
    logic [ADDR_WIDTH-1:0]   addr_q,     addr_d;
    logic [31:0]             wdata_q,    wdata_d;
    logic                    busy_q,     busy_d;
    logic                    ready_q,    ready_d;
    logic                    error_q,    error_d;
    logic [31:0]             rdata_q,    rdata_d;

    logic [7:0]              mem [DEPTH];

    // ------------------------------------------------------------------
    // Request qualification (evaluated on the live inputs while idle)
    // ------------------------------------------------------------------
    logic [2:0]              req_bytes;
    logic [ADDR_WIDTH:0]     last_byte;
    logic                    req_reject;

    always_comb begin
        case (Size)
            2'b00:   req_bytes = 3'd1;
            2'b01:   req_bytes = 3'd2;
            default: req_bytes = 3'd4;
        endcase
        // A carry into the top bit means the access runs past the last byte.
        last_byte  = {1'b0, Address[ADDR_WIDTH-1:0]}
                   + (ADDR_WIDTH+1)'(req_bytes - 3'd1);
        req_reject = (Size == 2'b11)
                   | (|(Address >> ADDR_WIDTH))
                   | ((Size == 2'b01) & Address[0])
                   | ((Size == 2'b10) & (|Address[1:0]))
                   | last_byte[ADDR_WIDTH];
    end

    // ------------------------------------------------------------------
    // Byte lane mapping: lane i is bit range [8i+7:8i] of the right-aligned
    // data. Big-endian puts the most significant lane at the lowest address.
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0]   lane_idx [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            if (BIG_ENDIAN)
                lane_idx[i] = addr_q + ADDR_WIDTH'(nbytes_q - 3'(i) - 3'd1);
            else
                lane_idx[i] = addr_q + ADDR_WIDTH'(3'(i));
        end
    end

    // Load assembly and extension
    logic [31:0] load_raw;
    logic [31:0] load_val;
    logic        ext_bit;

    always_comb begin
        load_raw = '0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < nbytes_q)
                load_raw[8*i +: 8] = mem[lane_idx[i]];
        end
        ext_bit = 1'b0;
        if (!unsigned_q)
            ext_bit = (nbytes_q == 3'd1) ? load_raw[7] : load_raw[15];
        case (nbytes_q)
            3'd1:    load_val = {{24{ext_bit}}, load_raw[7:0]};
            3'd2:    load_val = {{16{ext_bit}}, load_raw[15:0]};
            default: load_val = load_raw;
        endcase
    end

    // The access edge is the ACCESS cycle whose counter has reached zero.
    logic access_now;
    logic mem_we;

    assign access_now = (state_q == S_ACCESS) && (cnt_q == 4'd0);
    // Gating with RST keeps a store from committing on the reset edge.
    assign mem_we     = RST && access_now && write_q;

    // Storage has no reset; only the bytes covered by the request change.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < nbytes_q)
                    mem[lane_idx[i]] <= wdata_q[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Controller next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        nbytes_d   = nbytes_q;
        unsigned_d = unsigned_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ready_d    = 1'b0;
        error_d    = 1'b0;
        rdata_d    = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (Req) begin
                    write_d    = Write;
                    nbytes_d   = req_bytes;
                    unsigned_d = Unsigned;
                    addr_d     = Address[ADDR_WIDTH-1:0];
                    wdata_d    = WriteData;
                    if (req_reject) begin
                        state_d = S_DONE;
                        ready_d = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        cnt_d   = 4'(WAIT_STATES);
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (!write_q)
                        rdata_d = load_val;
                    state_d = S_DONE;
                    ready_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            write_q    <= 1'b0;
            nbytes_q   <= 3'd1;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            write_q    <= write_d;
            nbytes_q   <= nbytes_d;
            unsigned_q <= unsigned_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            error_q    <= error_d;
            rdata_q    <= rdata_d;
        end
    end

    assign Busy     = busy_q;
    assign Ready    = ready_q;
    assign Error    = error_q;
    assign ReadData = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_ctl
// Purpose  : Self-checking bench for data_memory_ctl. Two instances run side
//            by side: dut_a (no wait states, big-endian) and dut_b (three
//            wait states, little-endian). Each request pushes its expected
//            Error/ReadData into a per-instance queue; a monitor pops and
//            compares on every Ready pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_ctl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut_a: WAIT_STATES=0, BIG_ENDIAN=1
    logic        rst_a, req_a, wr_a, uns_a;
    logic [1:0]  size_a;
    logic [31:0] addr_a, wd_a;
    logic        busy_a, ready_a, error_a;
    logic [31:0] rdata_a;

    // dut_b: WAIT_STATES=3, BIG_ENDIAN=0
    logic        rst_b, req_b, wr_b, uns_b;
    logic [1:0]  size_b;
    logic [31:0] addr_b, wd_b;
    logic        busy_b, ready_b, error_b;
    logic [31:0] rdata_b;

    data_memory_ctl #(.ADDR_WIDTH(8), .WAIT_STATES(0), .BIG_ENDIAN(1'b1)) dut_a (
        .CLK(clk), .RST(rst_a), .Req(req_a), .Write(wr_a), .Size(size_a),
        .Unsigned(uns_a), .Address(addr_a), .WriteData(wd_a),
        .Busy(busy_a), .Ready(ready_a), .Error(error_a), .ReadData(rdata_a)
    );

    data_memory_ctl #(.ADDR_WIDTH(8), .WAIT_STATES(3), .BIG_ENDIAN(1'b0)) dut_b (
        .CLK(clk), .RST(rst_b), .Req(req_b), .Write(wr_b), .Size(size_b),
        .Unsigned(uns_b), .Address(addr_b), .WriteData(wd_b),
        .Busy(busy_b), .Ready(ready_b), .Error(error_b), .ReadData(rdata_b)
    );

    typedef struct {
        logic        err;
        logic [31:0] rd;
        int          id;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int errors = 0;
    int checks = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // ------------------------------------------------------------------
    // Monitors: compare whenever a Ready pulse is presented
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        if (ready_a === 1'b1) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_ready", 32'd1, 32'd0);
            end else begin
                e = q_a.pop_front();
                chk($sformatf("a%0d_error", e.id), {31'd0, error_a}, {31'd0, e.err});
                chk($sformatf("a%0d_rdata", e.id), rdata_a, e.rd);
            end
        end else if (error_a !== 1'b0) begin
            chk("a_error_without_ready", {31'd0, error_a}, 32'd0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (ready_b === 1'b1) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_ready", 32'd1, 32'd0);
            end else begin
                e = q_b.pop_front();
                chk($sformatf("b%0d_error", e.id), {31'd0, error_b}, {31'd0, e.err});
                chk($sformatf("b%0d_rdata", e.id), rdata_b, e.rd);
            end
        end else if (error_b !== 1'b0) begin
            chk("b_error_without_ready", {31'd0, error_b}, 32'd0);
        end
    end

    // ------------------------------------------------------------------
    // Issue one request and measure the Ready latency, counted in cycles
    // after the acceptance edge (1 = the cycle right after it).
    // hold_req pulses Req while the request is in flight.
    // ------------------------------------------------------------------
    task automatic issue(input int sel, input int id, input logic wr,
                         input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic exp_err, input logic [31:0] exp_rd,
                         input int exp_lat, input logic hold_req);
        exp_t e;
        int   n;
        logic seen;
        string tag;
        tag = $sformatf("%s%0d", (sel == 0) ? "a" : "b", id);
        e.err = exp_err;
        e.rd  = exp_rd;
        e.id  = id;
        @(negedge clk);
        if (sel == 0) begin
            req_a = 1'b1; wr_a = wr; size_a = sz; uns_a = uns; addr_a = addr; wd_a = wd;
            q_a.push_back(e);
        end else begin
            req_b = 1'b1; wr_b = wr; size_b = sz; uns_b = uns; addr_b = addr; wd_b = wd;
            q_b.push_back(e);
        end
        @(posedge clk);
        #1;
        chk({tag, "_busy"}, {31'd0, (sel == 0) ? busy_a : busy_b}, 32'd1);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 30) begin
            @(negedge clk);
            n++;
            if (sel == 0) begin
                req_a = 1'b0;
            end else begin
                req_b = hold_req && (n % 2 == 1) && (n < exp_lat);
            end
            seen = (sel == 0) ? ready_a : ready_b;
        end
        if (sel != 0) req_b = 1'b0;
        chk({tag, "_latency"}, seen ? n : 32'hFFFF_FFFF, exp_lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int extra;
        rst_a = 1'b0; req_a = 1'b0; wr_a = 1'b0; size_a = 2'b00; uns_a = 1'b0;
        addr_a = '0; wd_a = '0;
        rst_b = 1'b0; req_b = 1'b0; wr_b = 1'b0; size_b = 2'b00; uns_b = 1'b0;
        addr_b = '0; wd_b = '0;
        // Reset with Req asserted: reset must win.
        req_a = 1'b1;
        repeat (3) @(negedge clk);
        req_a = 1'b0;
        chk("a_reset_busy",  {31'd0, busy_a},  32'd0);
        chk("a_reset_ready", {31'd0, ready_a}, 32'd0);
        chk("a_reset_error", {31'd0, error_a}, 32'd0);
        chk("a_reset_rdata", rdata_a, 32'd0);
        chk("b_reset_busy",  {31'd0, busy_b},  32'd0);
        chk("b_reset_rdata", rdata_b, 32'd0);
        rst_a = 1'b1;
        rst_b = 1'b1;

        // ---------------- dut_a: W=0, big-endian, latency 2 ----------------
        //        sel id wr  size  uns  addr          wdata         err  rdata         lat
        issue(0,  1, 1, 2'b10, 0, 32'h04,       32'h11223344, 0, 32'h00000000, 2, 0);
        issue(0,  2, 0, 2'b10, 0, 32'h04,       32'h0,        0, 32'h11223344, 2, 0);
        issue(0,  3, 0, 2'b00, 0, 32'h04,       32'h0,        0, 32'h00000011, 2, 0);
        issue(0,  4, 1, 2'b10, 0, 32'h08,       32'h01020304, 0, 32'h00000011, 2, 0);
        issue(0,  5, 1, 2'b00, 0, 32'h09,       32'h00000080, 0, 32'h00000011, 2, 0);
        issue(0,  6, 0, 2'b00, 0, 32'h09,       32'h0,        0, 32'hFFFFFF80, 2, 0);
        issue(0,  7, 0, 2'b00, 1, 32'h09,       32'h0,        0, 32'h00000080, 2, 0);
        issue(0,  8, 1, 2'b01, 0, 32'h0A,       32'h0000BEEF, 0, 32'h00000080, 2, 0);
        issue(0,  9, 0, 2'b01, 0, 32'h0A,       32'h0,        0, 32'hFFFFBEEF, 2, 0);
        issue(0, 10, 1, 2'b01, 0, 32'h0B,       32'h00001234, 1, 32'hFFFFBEEF, 1, 0);
        issue(0, 11, 0, 2'b10, 0, 32'h08,       32'h0,        0, 32'h0180BEEF, 2, 0);
        issue(0, 12, 0, 2'b10, 0, 32'h100,      32'h0,        1, 32'h0180BEEF, 1, 0);
        issue(0, 13, 0, 2'b11, 0, 32'h04,       32'h0,        1, 32'h0180BEEF, 1, 0);
        issue(0, 14, 0, 2'b01, 0, 32'h09,       32'h0,        1, 32'h0180BEEF, 1, 0);
        issue(0, 15, 0, 2'b10, 0, 32'h06,       32'h0,        1, 32'h0180BEEF, 1, 0);
        issue(0, 16, 0, 2'b01, 1, 32'h0A,       32'h0,        0, 32'h0000BEEF, 2, 0);
        issue(0, 17, 1, 2'b10, 0, 32'hFC,       32'hCAFEF00D, 0, 32'h0000BEEF, 2, 0);
        issue(0, 18, 0, 2'b10, 0, 32'hFC,       32'h0,        0, 32'hCAFEF00D, 2, 0);
        issue(0, 19, 0, 2'b00, 1, 32'hFF,       32'h0,        0, 32'h0000000D, 2, 0);
        issue(0, 20, 0, 2'b00, 1, 32'h800000FF, 32'h0,        1, 32'h0000000D, 1, 0);

        // ---------------- dut_b: W=3, little-endian, latency 5 -------------
        issue(1,  1, 1, 2'b10, 0, 32'h10,       32'h11223344, 0, 32'h00000000, 5, 0);
        // Req pulses while ACCESS is counting must not start anything new.
        issue(1,  2, 0, 2'b10, 0, 32'h10,       32'h0,        0, 32'h11223344, 5, 1);
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (ready_b) extra++;
        end
        chk("b_no_extra_ready", extra, 0);
        issue(1,  3, 0, 2'b00, 0, 32'h10,       32'h0,        0, 32'h00000044, 5, 0);
        issue(1,  4, 0, 2'b00, 0, 32'h13,       32'h0,        0, 32'h00000011, 5, 0);
        issue(1,  5, 0, 2'b01, 0, 32'h12,       32'h0,        0, 32'h00001122, 5, 0);
        issue(1,  6, 1, 2'b01, 0, 32'h14,       32'h00008001, 0, 32'h00001122, 5, 0);
        issue(1,  7, 0, 2'b01, 0, 32'h14,       32'h0,        0, 32'hFFFF8001, 5, 0);
        issue(1,  8, 0, 2'b00, 0, 32'h15,       32'h0,        0, 32'hFFFFFF80, 5, 0);
        issue(1,  9, 0, 2'b10, 0, 32'h100,      32'h0,        1, 32'hFFFFFF80, 1, 0);

        // Reset during a store: accepted at k, RST low sampled at k+2.
        @(negedge clk);
        req_b = 1'b1; wr_b = 1'b1; size_b = 2'b10; uns_b = 1'b0;
        addr_b = 32'h10; wd_b = 32'hDEADBEEF;
        @(posedge clk);            // k
        @(negedge clk);
        req_b = 1'b0;
        @(negedge clk);            // between k+1 and k+2
        rst_b = 1'b0;
        @(negedge clk);            // after k+2
        chk("b_abort_busy",  {31'd0, busy_b},  32'd0);
        chk("b_abort_ready", {31'd0, ready_b}, 32'd0);
        chk("b_abort_rdata", rdata_b, 32'd0);
        rst_b = 1'b1;
        issue(1, 10, 0, 2'b10, 0, 32'h10,       32'h0,        0, 32'h11223344, 5, 0);

        repeat (4) @(negedge clk);
        chk("a_queue_drained", q_a.size(), 0);
        chk("b_queue_drained", q_b.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
